// File: rtl/aes_pkg.sv
// Shared AES clearing-PRNG scheduler definitions: requester count default and
// the sparse FSM state encoding.
package aes_pkg;

    localparam int unsigned ClearingNumReq = 3;

    // Every pair of valid codes differs in four bits, so any single or double
    // bit flip on the state register lands on an invalid code.
    typedef enum logic [5:0] {
        CLR_IDLE   = 6'b101001,
        CLR_GRANT  = 6'b010011,
        CLR_RESEED = 6'b110100,
        CLR_ERROR  = 6'b001110
    } clr_state_e;

endpackage

// File: rtl/aes_prng_clearing_rr.sv
// Round-robin pick: the first set request at or above ptr, wrapping from the
// top requester back to requester 0.
module aes_prng_clearing_rr
    import aes_pkg::*;
#(
    parameter int unsigned NumReq = ClearingNumReq,
    parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   winner,
    output logic              valid
);

    logic [IdxW:0] cand;

    // Scan from the farthest offset down so the nearest set request wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IdxW + 1)'(i);
            if (cand >= (IdxW + 1)'(NumReq)) begin
                cand = cand - (IdxW + 1)'(NumReq);
            end
            if (req[cand[IdxW-1:0]]) begin
                winner = cand[IdxW-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_prng_clearing_sched.sv
// Scheduler sharing one clearing PRNG among several requesters, with
// software-triggered and transfer-count-triggered reseeding.
module aes_prng_clearing_sched
    import aes_pkg::*;
#(
    parameter int unsigned NumReq = ClearingNumReq,
    parameter int unsigned RateW  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] ack_o,
    output logic              prng_data_req_o,
    input  logic              prng_data_ack_i,
    output logic              prng_reseed_req_o,
    input  logic              prng_reseed_ack_i,
    input  logic              reseed_trig_i,
    input  logic [RateW-1:0]  reseed_rate_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned     IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    clr_state_e       state_q, state_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic [IdxW-1:0]  grant_q, grant_d;
    logic [RateW-1:0] cnt_q, cnt_d;
    logic             reseed_pend_q, reseed_pend_d;
    logic [IdxW-1:0]  rr_winner;
    logic             rr_valid;
    logic             data_done;
    logic             reseed_done;

    aes_prng_clearing_rr #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr (
        .req    (req_i),
        .ptr    (ptr_q),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= CLR_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            cnt_q         <= '0;
            reseed_pend_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            reseed_pend_q <= reseed_pend_d;
        end
    end

    // A pending reseed always wins in IDLE; a grant is never preempted.
    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        grant_d           = grant_q;
        ack_o             = '0;
        prng_data_req_o   = 1'b0;
        prng_reseed_req_o = 1'b0;
        busy_o            = 1'b0;
        err_o             = 1'b0;
        data_done         = 1'b0;
        reseed_done       = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                busy_o = reseed_pend_q;
                if (reseed_pend_q) begin
                    state_d = CLR_RESEED;
                end else if (rr_valid) begin
                    grant_d = rr_winner;
                    state_d = CLR_GRANT;
                end
            end
            CLR_GRANT: begin
                busy_o          = 1'b1;
                prng_data_req_o = 1'b1;
                ack_o[grant_q]  = prng_data_ack_i;
                if (prng_data_ack_i) begin
                    data_done = 1'b1;
                    ptr_d     = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
                    state_d   = CLR_IDLE;
                end
            end
            CLR_RESEED: begin
                busy_o            = 1'b1;
                prng_reseed_req_o = 1'b1;
                if (prng_reseed_ack_i) begin
                    reseed_done = 1'b1;
                    state_d     = CLR_IDLE;
                end
            end
            CLR_ERROR: begin
                err_o = 1'b1;
            end
            default: begin
                err_o   = 1'b1;
                state_d = CLR_ERROR;
            end
        endcase
    end

    // Threshold is compared against the post-transfer count so the reseed is
    // queued before the next grant can start.
    always_comb begin
        cnt_d = cnt_q;
        if (reseed_done) begin
            cnt_d = '0;
        end else if (data_done && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        reseed_pend_d = reseed_pend_q;
        if (reseed_trig_i && (state_q != CLR_RESEED)) begin
            reseed_pend_d = 1'b1;
        end
        if ((reseed_rate_i != '0) && (cnt_d >= reseed_rate_i)) begin
            reseed_pend_d = 1'b1;
        end
        if (reseed_done) begin
            reseed_pend_d = 1'b0;
        end
    end

    grant_req_held_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == CLR_GRANT) |-> req_i[grant_q]);

    ack_onehot_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(ack_o));

    req_exclusive_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(prng_data_req_o && prng_reseed_req_o));

endmodule

// File: tb/tb_aes_prng_clearing_sched.sv
// Self-checking bench for aes_prng_clearing_sched: directed scenarios plus a
// randomized run, all compared cycle by cycle against a transaction-level model.
module tb_aes_prng_clearing_sched;
    import aes_pkg::*;

    localparam int N    = 3;
    localparam int RW   = 16;
    localparam int MAXC = 65535;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_i = '0;
    logic [N-1:0]  ack_o;
    logic          prng_data_req_o;
    logic          prng_data_ack_i = 1'b0;
    logic          prng_reseed_req_o;
    logic          prng_reseed_ack_i = 1'b0;
    logic          reseed_trig_i = 1'b0;
    logic [RW-1:0] reseed_rate_i = '0;
    logic          busy_o;
    logic          err_o;

    logic [N-1:0]  sat_req = '0;
    logic [N-1:0]  sat_ack;
    logic          sat_dreq;
    logic          sat_dack = 1'b0;
    logic          sat_rreq;
    logic          sat_busy;
    logic          sat_err;

    always #5 clk = ~clk;

    aes_prng_clearing_sched #(.NumReq(N), .RateW(RW)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_i             (req_i),
        .ack_o             (ack_o),
        .prng_data_req_o   (prng_data_req_o),
        .prng_data_ack_i   (prng_data_ack_i),
        .prng_reseed_req_o (prng_reseed_req_o),
        .prng_reseed_ack_i (prng_reseed_ack_i),
        .reseed_trig_i     (reseed_trig_i),
        .reseed_rate_i     (reseed_rate_i),
        .busy_o            (busy_o),
        .err_o             (err_o)
    );

    // Narrow-counter instance so counter saturation is reachable in a short run.
    aes_prng_clearing_sched #(.NumReq(N), .RateW(8)) dut_sat (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_i             (sat_req),
        .ack_o             (sat_ack),
        .prng_data_req_o   (sat_dreq),
        .prng_data_ack_i   (sat_dack),
        .prng_reseed_req_o (sat_rreq),
        .prng_reseed_ack_i (1'b0),
        .reseed_trig_i     (1'b0),
        .reseed_rate_i     (8'd0),
        .busy_o            (sat_busy),
        .err_o             (sat_err)
    );

    int checks = 0;
    int failures = 0;

    // Model: mode 0 = waiting, 1 = serving requester m_who, 2 = reseeding.
    int     m_mode, m_who, m_next, m_count;
    bit     m_pend;
    logic [N-1:0] m_last_ack;

    int step_no;
    int ack_steps[$];
    int ack_who[$];
    int rreq_rises;
    int first_rreq_step;
    bit rreq_prev;
    bit capture_cnt;
    int cnt_after_reseed;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_who = 0; m_next = 0; m_count = 0; m_pend = 1'b0;
        m_last_ack = '0;
    endtask

    task automatic clear_log();
        step_no = 0;
        ack_steps.delete();
        ack_who.delete();
        rreq_rises = 0;
        first_rreq_step = -1;
        rreq_prev = 1'b0;
        capture_cnt = 1'b0;
        cnt_after_reseed = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_i = '0; prng_data_ack_i = 1'b0; prng_reseed_ack_i = 1'b0;
        reseed_trig_i = 1'b0; reseed_rate_i = '0;
        sat_req = '0; sat_dack = 1'b0;
        @(negedge clk);
        #1;
        check_output("rst_ack", 32'(ack_o), 0);
        check_output("rst_dreq", 32'(prng_data_req_o), 0);
        check_output("rst_rreq", 32'(prng_reseed_req_o), 0);
        check_output("rst_busy", 32'(busy_o), 0);
        check_output("rst_err", 32'(err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_log();
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic apply_stimulus(input logic [N-1:0] req, input logic dack, input logic rack,
                                  input logic trig, input logic [RW-1:0] rate);
        logic [N-1:0] e_ack;
        int           newc;
        bit           np;
        bit           found;
        req_i = req; prng_data_ack_i = dack; prng_reseed_ack_i = rack;
        reseed_trig_i = trig; reseed_rate_i = rate;
        #1;
        e_ack = (m_mode == 1 && dack) ? N'(1 << m_who) : '0;
        check_output("ack", 32'(ack_o), 32'(e_ack));
        check_output("data_req", 32'(prng_data_req_o), 32'(m_mode == 1));
        check_output("reseed_req", 32'(prng_reseed_req_o), 32'(m_mode == 2));
        check_output("busy", 32'(busy_o), 32'(m_mode != 0 || m_pend));
        check_output("err", 32'(err_o), 0);
        check_output("cnt", 32'(dut.cnt_q), 32'(m_count));
        if (capture_cnt) begin
            cnt_after_reseed = int'(dut.cnt_q);
            capture_cnt = 1'b0;
        end
        if (prng_reseed_req_o && !rreq_prev) begin
            rreq_rises++;
            if (first_rreq_step < 0) first_rreq_step = step_no;
        end
        rreq_prev = prng_reseed_req_o;
        for (int i = 0; i < N; i++) begin
            if (ack_o[i]) begin
                ack_steps.push_back(step_no);
                ack_who.push_back(i);
            end
        end
        m_last_ack = e_ack;
        newc = m_count;
        if (m_mode == 1 && dack) newc = (m_count == MAXC) ? MAXC : m_count + 1;
        if (m_mode == 2 && rack) newc = 0;
        np = m_pend;
        if (trig && m_mode != 2) np = 1'b1;
        if (rate != 0 && newc >= int'(rate)) np = 1'b1;
        if (m_mode == 2 && rack) begin
            np = 1'b0;
            capture_cnt = 1'b1;
        end
        case (m_mode)
            0: begin
                if (m_pend) begin
                    m_mode = 2;
                end else if (req != '0) begin
                    found = 1'b0;
                    for (int i = 0; i < N; i++) begin
                        if (!found && req[(m_next + i) % N]) begin
                            m_who = (m_next + i) % N;
                            found = 1'b1;
                        end
                    end
                    m_mode = 1;
                end
            end
            1: if (dack) begin
                m_mode = 0;
                m_next = (m_who + 1) % N;
            end
            default: if (rack) m_mode = 0;
        endcase
        m_count = newc;
        m_pend = np;
        step_no++;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] r_req;
        logic [RW-1:0] r_rate;
        int later_acks, early_acks, sat_rreq_seen, sat_acks;
        bit trig_done;

        $display("[TB] start");
        model_reset();
        clear_log();

        // Round-robin order with all requesters active and an always-ready PRNG.
        do_reset();
        check_output("rst_state", 32'(dut.state_q), 32'(CLR_IDLE));
        check_output("rst_ptr", 32'(dut.ptr_q), 0);
        check_output("rst_pend", 32'(dut.reseed_pend_q), 0);
        for (int i = 0; i < 8; i++) apply_stimulus(3'b111, 1'b1, 1'b0, 1'b0, '0);
        check_output("rr_ack_count", 32'(ack_who.size()), 4);
        if (ack_who.size() >= 4) begin
            check_output("rr_order0", 32'(ack_who[0]), 0);
            check_output("rr_order1", 32'(ack_who[1]), 1);
            check_output("rr_order2", 32'(ack_who[2]), 2);
            check_output("rr_order3", 32'(ack_who[3]), 0);
            check_output("rr_first_latency", 32'(ack_steps[0]), 1);
            for (int i = 1; i < 4; i++)
                check_output("rr_spacing", 32'(ack_steps[i] - ack_steps[i-1]), 2);
        end

        // Auto reseed after four transfers; the count restarts and data resumes.
        do_reset();
        for (int i = 0; i < 16; i++)
            apply_stimulus(3'b010, 1'b1, 1'(m_mode == 2), 1'b0, 16'd4);
        early_acks = 0; later_acks = 0;
        foreach (ack_steps[i]) begin
            if (ack_steps[i] < first_rreq_step) early_acks++;
            else later_acks++;
        end
        check_output("auto_acks_before_reseed", 32'(early_acks), 4);
        check_output("auto_reseed_seen", 32'(first_rreq_step >= 0), 1);
        check_output("auto_cnt_cleared", 32'(cnt_after_reseed), 0);
        check_output("auto_data_resumed", 32'(later_acks > 0), 1);

        // Software trigger during a grant: the grant finishes, reseed follows.
        do_reset();
        apply_stimulus(3'b001, 1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(3'b001, 1'b0, 1'b0, 1'b1, '0);
        apply_stimulus(3'b001, 1'b1, 1'b0, 1'b0, '0);
        apply_stimulus(3'b000, 1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(3'b000, 1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(3'b000, 1'b0, 1'b1, 1'b0, '0);
        apply_stimulus(3'b000, 1'b0, 1'b0, 1'b0, '0);
        check_output("trig_grant_acked", 32'(ack_steps.size()), 1);
        if (ack_steps.size() >= 1)
            check_output("trig_reseed_after_grant", 32'(first_rreq_step - ack_steps[0]), 2);
        check_output("trig_one_episode", 32'(rreq_rises), 1);

        // Trigger coinciding with the count threshold: exactly one reseed.
        do_reset();
        trig_done = 1'b0;
        for (int i = 0; i < 14; i++) begin
            logic t;
            t = !trig_done && m_mode == 1 && m_count == 1;
            if (t) trig_done = 1'b1;
            apply_stimulus((rreq_rises > 0) ? 3'b000 : 3'b011, 1'(m_mode == 1),
                           1'(m_mode == 2), t, 16'd2);
        end
        check_output("merge_trig_fired", 32'(trig_done), 1);
        check_output("merge_one_episode", 32'(rreq_rises), 1);

        // Reset asserted in the middle of a reseed.
        do_reset();
        apply_stimulus(3'b001, 1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(3'b001, 1'b1, 1'b0, 1'b0, '0);
        apply_stimulus(3'b000, 1'b0, 1'b0, 1'b1, '0);
        apply_stimulus(3'b000, 1'b0, 1'b0, 1'b0, '0);
        apply_stimulus(3'b000, 1'b0, 1'b0, 1'b0, '0);
        check_output("midrst_in_reseed", 32'(prng_reseed_req_o), 1);
        check_output("midrst_ptr_before", 32'(dut.ptr_q), 1);
        rst_n = 1'b0;
        #1;
        check_output("midrst_rreq", 32'(prng_reseed_req_o), 0);
        check_output("midrst_busy", 32'(busy_o), 0);
        check_output("midrst_dreq", 32'(prng_data_req_o), 0);
        check_output("midrst_ack", 32'(ack_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_log();
        #1;
        check_output("midrst_state", 32'(dut.state_q), 32'(CLR_IDLE));
        check_output("midrst_ptr", 32'(dut.ptr_q), 0);
        @(negedge clk);

        // Randomized traffic, triggers and rate changes.
        do_reset();
        r_req = '0;
        r_rate = '0;
        for (int i = 0; i < 2500; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: r_rate = 16'd0;
                    1: r_rate = 16'd1;
                    2: r_rate = 16'd3;
                    default: r_rate = 16'd7;
                endcase
            end
            r_req = (r_req & ~m_last_ack) | (N'($urandom) & N'($urandom));
            apply_stimulus(r_req,
                           1'(m_mode == 1 && $urandom_range(0, 2) != 0),
                           1'(m_mode == 2 && $urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 29) == 0),
                           r_rate);
        end

        // Auto reseed disabled: a long run of transfers never reseeds.
        do_reset();
        for (int i = 0; i < 1000; i++) apply_stimulus(3'b111, 1'b1, 1'b0, 1'b0, '0);
        check_output("norate_no_reseed", 32'(rreq_rises), 0);
        check_output("norate_cnt", 32'(dut.cnt_q), 500);

        // Counter saturation on the narrow instance.
        do_reset();
        sat_req = '1;
        sat_dack = 1'b1;
        sat_rreq_seen = 0;
        sat_acks = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (sat_rreq) sat_rreq_seen++;
            if (sat_ack != '0) sat_acks++;
        end
        check_output("sat_transfers", 32'(sat_acks), 300);
        check_output("sat_cnt", 32'(dut_sat.cnt_q), 32'h0000_00FF);
        check_output("sat_no_reseed", 32'(sat_rreq_seen), 0);
        check_output("sat_err", 32'(sat_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
